// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: limits, payload field offsets, R-burst
// router states and the RID-to-master decode helper.
package axicb_pkg;

    localparam int MST_NB_MAX    = 4;
    localparam int ID_W_MAX      = 32;
    localparam int ARCH_ADDR_OFF = 0;
    localparam int RCH_ID_OFF    = 0;

    typedef logic [ID_W_MAX-1:0]   id_t;
    typedef id_t [MST_NB_MAX-1:0]  id_masks_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ROUTE = 2'd1,
        R_SINK  = 2'd2
    } r_state_e;

    // One-hot master hit for an ID; the lowest matching index wins.
    function automatic logic [MST_NB_MAX-1:0] mst_index(
        input id_t       id,
        input id_t       sel,
        input id_masks_t masks
    );
        logic [MST_NB_MAX-1:0] hit;
        hit = '0;
        for (int i = MST_NB_MAX - 1; i >= 0; i--) begin
            if ((id & sel) == (masks[i] & sel)) begin
                hit    = '0;
                hit[i] = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/axicb_mst_switch_rd_if.sv
// Read-switch bus bundle: per-master AR/R side plus the single slave port.
interface axicb_mst_switch_rd_if #(
    parameter int MST_NB = 4,
    parameter int ARCH_W = 8,
    parameter int RCH_W  = 8
);
    logic [MST_NB-1:0]        i_arvalid;
    logic [MST_NB-1:0]        i_arready;
    logic [MST_NB*ARCH_W-1:0] i_arch;
    logic [MST_NB-1:0]        i_rvalid;
    logic [MST_NB-1:0]        i_rready;
    logic [MST_NB-1:0]        i_rlast;
    logic [RCH_W-1:0]         i_rch;
    logic                     o_arvalid;
    logic                     o_arready;
    logic [ARCH_W-1:0]        o_arch;
    logic                     o_rvalid;
    logic                     o_rready;
    logic                     o_rlast;
    logic [RCH_W-1:0]         o_rch;
    logic                     o_r_misroute;

    // Switch view.
    modport slave (
        input  i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
        output i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready,
               o_r_misroute
    );

    // Environment view (masters and the downstream slave).
    modport master (
        output i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
        input  i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready,
               o_r_misroute
    );
endinterface

// File: rtl/axicb_round_robin.sv
// Round-robin arbiter: combinational one-hot grant searched from the
// pointer; the pointer moves past the grantee whenever en is high.
module axicb_round_robin #(
    parameter int N = 4
) (
    input  logic         aclk,
    input  logic         srst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gidx_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Grant the first requester at or after the pointer.
    always_comb begin
        grant   = '0;
        gidx_s  = ptr_q;
        idx_s   = ptr_q;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s = PTR_W'((int'(ptr_q) + k) % N);
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                gidx_s       = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the grantee on a completed transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            if (int'(gidx_s) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge aclk) begin
        if (srst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/axicb_mst_switch_rd.sv
// Slave-side read switch: round-robin AR arbitration onto one slave port,
// outstanding-read limiting, and RID-based R routing back to masters.
module axicb_mst_switch_rd
    import axicb_pkg::*;
#(
    parameter int                  AXI_ADDR_W      = 8,
    parameter int                  AXI_ID_W        = 8,
    parameter int                  MST_NB          = 4,
    parameter int                  SLV_OSTDREQ_NUM = 4,
    parameter logic [AXI_ID_W-1:0] ID_SEL_MASK     = 'h30,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK    = 'h00,
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK    = 'h10,
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK    = 'h20,
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK    = 'h30,
    parameter int                  ARCH_W          = 8,
    parameter int                  RCH_W           = 8
) (
    input logic                  aclk,
    input logic                  srst,
    axicb_mst_switch_rd_if.slave bus
);
    localparam int        CNT_W     = $clog2(SLV_OSTDREQ_NUM + 1);
    localparam id_masks_t MST_MASKS = {id_t'(MST3_ID_MASK), id_t'(MST2_ID_MASK),
                                       id_t'(MST1_ID_MASK), id_t'(MST0_ID_MASK)};

    // The master count is fixed and the AR payload must at least hold the address.
    if ((MST_NB != MST_NB_MAX) || (ARCH_ADDR_OFF + AXI_ADDR_W > ARCH_W)) begin : g_bad_cfg
        $error("axicb_mst_switch_rd: unsupported MST_NB or ARCH_W");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_q, lock_d;
    logic [MST_NB-1:0] lgrant_q, lgrant_d;
    r_state_e          r_state_q, r_state_d;
    logic [MST_NB-1:0] route_q, route_d;

    logic              full_s;
    logic [MST_NB-1:0] req_s;
    logic [MST_NB-1:0] grant_s;
    logic              ar_hs_s;
    logic              r_hs_s;
    logic              r_done_s;
    logic [MST_NB-1:0] hit_s;
    logic [MST_NB-1:0] sel_s;

    assign full_s   = (cnt_q == CNT_W'(SLV_OSTDREQ_NUM));
    assign ar_hs_s  = bus.o_arvalid & bus.o_arready;
    assign r_hs_s   = bus.o_rvalid & bus.o_rready;
    assign r_done_s = r_hs_s & bus.o_rlast;

    // Arbiter requests; a stalled grant is presented alone so it cannot move or be dropped by full.
    always_comb begin
        req_s = '0;
        if (lock_q) begin
            req_s = lgrant_q;
        end else begin
            req_s = bus.i_arvalid & {MST_NB{~full_s}};
        end
    end

    axicb_round_robin #(.N(MST_NB)) u_rr (
        .aclk  (aclk),
        .srst  (srst),
        .en    (ar_hs_s),
        .req   (req_s),
        .grant (grant_s)
    );

    // AR datapath: zero-latency mux of the grantee onto the slave port.
    always_comb begin
        bus.o_arvalid = 1'b0;
        bus.o_arch    = '0;
        bus.i_arready = '0;
        if (!srst) begin
            bus.o_arvalid = |(grant_s & bus.i_arvalid);
            for (int i = 0; i < MST_NB; i++) begin
                if (grant_s[i]) begin
                    bus.o_arch = bus.i_arch[i*ARCH_W +: ARCH_W];
                end else begin
                    bus.o_arch = bus.o_arch;
                end
            end
            bus.i_arready = grant_s & {MST_NB{bus.o_arready}};
        end else begin
            bus.o_arvalid = 1'b0;
        end
    end

    // Hold the grant while the slave back-pressures a valid request.
    always_comb begin
        lock_d   = bus.o_arvalid & ~bus.o_arready;
        lgrant_d = grant_s;
    end

    // Outstanding bursts: up on AR handshake, down on the last R beat, floor at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (ar_hs_s && !r_done_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!ar_hs_s && r_done_s) begin
            if (cnt_q == '0) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // R destination: decode RID on a first beat, otherwise the burst's held route.
    always_comb begin
        hit_s = mst_index(id_t'(bus.o_rch[RCH_ID_OFF +: AXI_ID_W]), id_t'(ID_SEL_MASK), MST_MASKS);
        if (r_state_q == R_IDLE) begin
            sel_s = hit_s;
        end else begin
            sel_s = route_q;
        end
    end

    // R outputs: forward to the selected master, or sink the beat when nobody owns it.
    always_comb begin
        bus.i_rvalid     = '0;
        bus.i_rlast      = '0;
        bus.o_rready     = 1'b0;
        bus.o_r_misroute = 1'b0;
        bus.i_rch        = bus.o_rch;
        if (!srst && bus.o_rvalid) begin
            bus.i_rvalid = sel_s;
            bus.i_rlast  = sel_s & {MST_NB{bus.o_rlast}};
            if (sel_s == '0) begin
                bus.o_rready     = 1'b1;
                bus.o_r_misroute = 1'b1;
            end else begin
                bus.o_rready     = |(sel_s & bus.i_rready);
                bus.o_r_misroute = 1'b0;
            end
        end else begin
            bus.o_rready = 1'b0;
        end
    end

    // Burst route FSM: capture the route on the first beat, release on rlast.
    always_comb begin
        r_state_d = r_state_q;
        route_d   = route_q;
        case (r_state_q)
            R_IDLE: begin
                if (r_hs_s && !bus.o_rlast) begin
                    route_d   = hit_s;
                    r_state_d = (hit_s != '0) ? R_ROUTE : R_SINK;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_ROUTE, R_SINK: begin
                if (r_done_s) begin
                    route_d   = '0;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = r_state_q;
                end
            end
            default: begin
                route_d   = '0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge aclk) begin
        if (srst) begin
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lgrant_q  <= '0;
            r_state_q <= R_IDLE;
            route_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lgrant_q  <= lgrant_d;
            r_state_q <= r_state_d;
            route_q   <= route_d;
        end
    end
endmodule
